// File: rtl/score4_pkg.sv
// rtl/score4_pkg.sv - shared constants, cell/board types and FSM states for score4_ctrl
package score4_pkg;

   localparam int COLS = 7;
   localparam int ROWS = 6;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      RED   = 2'b01,
      GREEN = 2'b10
   } cell_t;

   // panel[col][row], row 5 is the bottom of the board
   typedef logic [COLS-1:0][ROWS-1:0][1:0] panel_t;

   typedef enum logic [3:0] {
      SELECT, DROP, CHK_H, CHK_V, CHK_D1, CHK_D2, WIN, DRAW, CLEAR
   } state_t;

   typedef enum logic [1:0] {
      DIR_H, DIR_V, DIR_D1, DIR_D2
   } dir_t;

   function automatic logic [2:0] onehot_col(input logic [COLS-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < COLS; i++)
         if (oh[i[2:0]]) idx = 3'(i);
      return idx;
   endfunction

endpackage

// File: rtl/score4_if.sv
// rtl/score4_if.sv - player controls and board/status outputs of score4_ctrl
interface score4_if;
   import score4_pkg::*;

   logic            left;
   logic            right;
   logic            put;
   panel_t          panel;
   logic [COLS-1:0] play;
   logic            turn;
   logic            game_over;
   logic [1:0]      winner;

   modport master (
      output left, right, put,
      input  panel, play, turn, game_over, winner
   );

   modport slave (
      input  left, right, put,
      output panel, play, turn, game_over, winner
   );
endinterface

// File: rtl/score4_line_count.sv
// rtl/score4_line_count.sv - length of the same-colour line through one cell along one direction
module score4_line_count
   import score4_pkg::*;
(
   input  panel_t     panel,
   input  logic [2:0] col,
   input  logic [2:0] row,
   input  cell_t      colour,
   input  dir_t       dir,
   output logic [2:0] count
);

   int dc;
   int dr;

   always_comb begin
      dc = 1;
      dr = 1;
      case (dir)
         DIR_H:   begin dc = 1; dr = 0;  end
         DIR_V:   begin dc = 0; dr = 1;  end
         DIR_D1:  begin dc = 1; dr = -1; end
         default: begin dc = 1; dr = 1;  end
      endcase
   end

   // Walk up to three cells each way, stopping at the first gap or board edge
   always_comb begin
      int  c;
      int  r;
      logic run;
      count = 3'd1;
      c = 0;
      r = 0;
      run = 1'b0;
      for (int s = -1; s <= 1; s += 2) begin
         run = 1'b1;
         for (int k = 1; k <= 3; k++) begin
            c = int'(col) + s * k * dc;
            r = int'(row) + s * k * dr;
            if (run && c >= 0 && c < COLS && r >= 0 && r < ROWS &&
                panel[c[2:0]][r[2:0]] == colour)
               count = count + 3'd1;
            else
               run = 1'b0;
         end
      end
   end

endmodule

// File: rtl/score4_ctrl.sv
// rtl/score4_ctrl.sv - four-in-a-row game controller; SCORE4_TIMEOUT_EN adds a per-move timeout
module score4_ctrl
   import score4_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input logic   clk,
   input logic   rst,
   score4_if.slave bus
);

   state_t          state, state_nx;
   panel_t          panel;
   logic [COLS-1:0] play;
   logic            turn;
   logic [1:0]      winner;
   logic [2:0]      col_q, row_q, sel_col, drop_row, count;
   logic            col_full, board_full, win, put_ok, shift_r, shift_l;
   cell_t           colour;
   dir_t            dir;

   if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
      $error("TIMEOUT_CYCLES must be positive");
   end

   assign sel_col  = onehot_col(play);
   assign col_full = panel[sel_col][0] != EMPTY;
   assign put_ok   = bus.put && !col_full;
   assign shift_r  = !bus.put && bus.right && !bus.left;
   assign shift_l  = !bus.put && bus.left && !bus.right;
   assign colour   = turn ? GREEN : RED;
   assign win      = count >= 3'd4;

   // Pieces stack from the bottom, so the last empty row scanned top-down is the landing row
   always_comb begin
      board_full = 1'b1;
      drop_row   = '0;
      for (int c = 0; c < COLS; c++)
         if (panel[c[2:0]][0] == EMPTY) board_full = 1'b0;
      for (int r = 0; r < ROWS; r++)
         if (panel[col_q][r[2:0]] == EMPTY) drop_row = 3'(r);
   end

   always_comb begin
      dir = DIR_D2;
      case (state)
         CHK_H:   dir = DIR_H;
         CHK_V:   dir = DIR_V;
         CHK_D1:  dir = DIR_D1;
         default: dir = DIR_D2;
      endcase
   end

   score4_line_count u_line (
      .panel  (panel),
      .col    (col_q),
      .row    (row_q),
      .colour (colour),
      .dir    (dir),
      .count  (count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= SELECT;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         SELECT:    if (put_ok) state_nx = DROP;
         DROP:      state_nx = CHK_H;
         CHK_H:     state_nx = win ? WIN : CHK_V;
         CHK_V:     state_nx = win ? WIN : CHK_D1;
         CHK_D1:    state_nx = win ? WIN : CHK_D2;
         CHK_D2:    state_nx = win ? WIN : (board_full ? DRAW : SELECT);
         WIN, DRAW: if (bus.put) state_nx = CLEAR;
         CLEAR:     state_nx = SELECT;
         default:   state_nx = SELECT;
      endcase
   end

`ifdef SCORE4_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt;
   logic          timeout_hit;

   assign timeout_hit = (state == SELECT) && !put_ok && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Held at zero outside SELECT so every return to SELECT starts a fresh move timer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                        to_cnt <= '0;
      else if (state != SELECT || put_ok || timeout_hit) to_cnt <= '0;
      else                                             to_cnt <= to_cnt + 1'b1;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         panel  <= '0;
         play   <= COLS'(1);
         turn   <= 1'b0;
         winner <= 2'b00;
         col_q  <= '0;
         row_q  <= '0;
      end else begin
         case (state)
            SELECT: begin
               if (put_ok)       col_q <= sel_col;
               else if (shift_r) play  <= {play[COLS-2:0], play[COLS-1]};
               else if (shift_l) play  <= {play[0], play[COLS-1:1]};
`ifdef SCORE4_TIMEOUT_EN
               if (timeout_hit) turn <= ~turn;
`endif
            end
            DROP: begin
               panel[col_q][drop_row] <= colour;
               row_q                  <= drop_row;
            end
            CHK_H, CHK_V, CHK_D1, CHK_D2: begin
               if (win)                                 winner <= colour;
               else if (state == CHK_D2 && !board_full) turn   <= ~turn;
            end
            CLEAR: begin
               panel  <= '0;
               play   <= COLS'(1);
               turn   <= 1'b0;
               winner <= 2'b00;
            end
            default: ;
         endcase
      end
   end

   assign bus.panel     = panel;
   assign bus.play      = play;
   assign bus.turn      = turn;
   assign bus.winner    = winner;
   assign bus.game_over = (state == WIN) || (state == DRAW);

endmodule

// File: tb/tb_score4_ctrl.sv
// tb/tb_score4_ctrl.sv - self-checking bench for score4_ctrl against a board-level game model
module tb_score4_ctrl;

`ifdef SCORE4_TIMEOUT_EN
   localparam int TO_CYC = 8;
`else
   localparam int TO_CYC = 1000;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   score4_if u_if ();

   score4_ctrl #(.TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   int bd[7][6];
   int m_play, m_turn, m_winner;
   bit m_over;

   // Full no-win board: column c holds a(c)^b(h) with a=0100101, bottom three vs top three rows
   int draw_seq[42] = '{0,1,0,1,0,1,2,4,2,4,2,4,3,6,3,6,3,6,
                        5,0,5,0,5,0,
                        1,2,1,2,1,2,4,3,4,3,4,3,6,5,6,5,6,5};

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int c = 0; c < 7; c++)
         for (int r = 0; r < 6; r++) bd[c][r] = 0;
      m_play = 0; m_turn = 0; m_winner = 0; m_over = 1'b0;
   endtask

   function automatic bit has_four(input int colour);
      for (int c = 0; c < 7; c++)
         for (int r = 0; r < 6; r++)
            for (int d = 0; d < 4; d++) begin
               int dc = (d == 1) ? 0 : 1;
               int dr = (d == 0) ? 0 : ((d == 3) ? -1 : 1);
               int n = 0;
               for (int k = 0; k < 4; k++) begin
                  int cc = c + k * dc;
                  int rr = r + k * dr;
                  if (cc < 7 && rr >= 0 && rr < 6 && bd[cc][rr] == colour) n++;
               end
               if (n == 4) return 1'b1;
            end
      return 1'b0;
   endfunction

   function automatic bit board_full();
      for (int c = 0; c < 7; c++)
         if (bd[c][0] == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [83:0] exp_panel();
      logic [83:0] p = '0;
      for (int c = 0; c < 7; c++)
         for (int r = 0; r < 6; r++) p[c*12 + r*2 +: 2] = 2'(bd[c][r]);
      return p;
   endfunction

   task automatic model_step(input bit l, input bit r, input bit p, output bit acc);
      int row = -1;
      acc = 1'b0;
      if (m_over) begin
         if (p) model_clear();
      end else if (p) begin
         for (int k = 0; k < 6; k++) if (bd[m_play][k] == 0) row = k;
         if (row >= 0) begin
            acc = 1'b1;
            bd[m_play][row] = m_turn + 1;
            if (has_four(m_turn + 1)) begin m_over = 1'b1; m_winner = m_turn + 1; end
            else if (board_full())    begin m_over = 1'b1; m_winner = 0; end
            else                      m_turn = 1 - m_turn;
         end
      end else if (l && !r) m_play = (m_play + 6) % 7;
      else if (r && !l)     m_play = (m_play + 1) % 7;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".panel"},  u_if.panel,     exp_panel());
      check({tag, ".play"},   u_if.play,      128'(1) << m_play);
      check({tag, ".turn"},   u_if.turn,      128'(m_turn));
      check({tag, ".over"},   u_if.game_over, 128'(m_over));
      check({tag, ".winner"}, u_if.winner,    128'(m_winner));
   endtask

   task automatic clear_inputs();
      u_if.left = 1'b0; u_if.right = 1'b0; u_if.put = 1'b0;
   endtask

   // One input pulse from a falling edge; a put waits out DROP and all CHK states
   task automatic act(input bit l, input bit r, input bit p, input bit noise);
      bit acc;
      u_if.left = l; u_if.right = r; u_if.put = p;
      @(negedge clk);
      clear_inputs();
      model_step(l, r, p, acc);
      if (p) begin
         for (int i = 0; i < 5; i++) begin
            if (acc && noise) begin
               u_if.left  = 1'($urandom_range(0, 1));
               u_if.right = 1'($urandom_range(0, 1));
               u_if.put   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            clear_inputs();
         end
      end
   endtask

   task automatic move(input int col, input bit noise);
      while (m_play != col) begin
         if (((col - m_play + 7) % 7) <= 3) act(1'b0, 1'b1, 1'b0, 1'b0);
         else                                 act(1'b1, 1'b0, 1'b0, 1'b0);
      end
      act(1'b0, 1'b0, 1'b1, noise);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_clear();
   endtask

   initial begin
      bit acc;
      clear_inputs();
      rst = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      check_all("reset");
      rst = 1'b1;
      @(negedge clk);
      check_all("idle");

      // Reset asserted while the move is in CHK_V must leave no trace
      act(1'b0, 1'b1, 1'b0, 1'b0);
      act(1'b0, 1'b1, 1'b0, 1'b0);
      u_if.put = 1'b1;
      @(negedge clk);
      u_if.put = 1'b0;
      @(negedge clk);
      check("rstchk.placed", u_if.panel[2][5], 2'b01);
      @(negedge clk);
      rst = 1'b0;
      #1;
      model_clear();
      check_all("rstchk.async");
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check_all("rstchk.after");

`ifdef SCORE4_TIMEOUT_EN
      do_reset();
      repeat (7) @(negedge clk);
      check("timeout.before", u_if.turn, 1'b0);
      @(negedge clk);
      check("timeout.toggle", u_if.turn, 1'b1);
      check("timeout.board", u_if.panel, 84'd0);
      repeat (8) @(negedge clk);
      check("timeout.again", u_if.turn, 1'b0);
`else
      do_reset();
      repeat (7) act(1'b0, 1'b1, 1'b0, 1'b0);
      check("rot.right7", u_if.play, 7'b0000001);
      do_reset();
      act(1'b1, 1'b0, 1'b0, 1'b0);
      check("rot.left1", u_if.play, 7'b1000000);
      act(1'b1, 1'b1, 1'b0, 1'b0);
      check("rot.both", u_if.play, 7'b1000000);
      act(1'b0, 1'b1, 1'b1, 1'b0);
      check("prio.play", u_if.play, 7'b1000000);
      check("prio.cell", u_if.panel[6][5], 2'b01);
      check_all("prio");

      do_reset();
      repeat (3) act(1'b0, 1'b1, 1'b0, 1'b0);
      model_step(1'b0, 1'b0, 1'b1, acc);
      u_if.put = 1'b1;
      @(negedge clk);
      u_if.put = 1'b0;
      check("drop.e0", u_if.panel[3][5], 2'b00);
      @(negedge clk);
      check("drop.e1", u_if.panel[3][5], 2'b01);
      repeat (3) @(negedge clk);
      check("drop.e4turn", u_if.turn, 1'b0);
      @(negedge clk);
      check("drop.e5turn", u_if.turn, 1'b1);
      check_all("drop");
      move(3, 1'b0);
      check("drop.second", u_if.panel[3][4], 2'b10);

      do_reset();
      repeat (6) move(0, 1'b0);
      check_all("full.six");
      act(1'b0, 1'b0, 1'b1, 1'b0);
      check("full.top", u_if.panel[0][0], 2'b10);
      check("full.turn", u_if.turn, 1'b0);
      check_all("full.ignored");
      act(1'b0, 1'b1, 1'b0, 1'b0);
      check("full.select", u_if.play, 7'b0000010);

      do_reset();
      move(0, 1'b0); move(0, 1'b0); move(1, 1'b0);
      move(1, 1'b0); move(2, 1'b0); move(2, 1'b0);
      act(1'b0, 1'b1, 1'b0, 1'b0);
      model_step(1'b0, 1'b0, 1'b1, acc);
      u_if.put = 1'b1;
      @(negedge clk);
      u_if.put = 1'b0;
      @(negedge clk);
      check("win.e1over", u_if.game_over, 1'b0);
      @(negedge clk);
      check("win.e2over", u_if.game_over, 1'b1);
      check("win.e2winner", u_if.winner, 2'b01);
      repeat (3) @(negedge clk);
      check_all("win");
      u_if.put = 1'b1;
      @(negedge clk);
      u_if.put = 1'b0;
      model_step(1'b0, 1'b0, 1'b1, acc);
      check("clear.over", u_if.game_over, 1'b0);
      @(negedge clk);
      check("clear.panel", u_if.panel, 84'd0);
      check_all("clear");

      do_reset();
      for (int i = 0; i < 42; i++) move(draw_seq[i], i == 41);
      check("draw.over", u_if.game_over, 1'b1);
      check("draw.winner", u_if.winner, 2'b00);
      check_all("draw");
      act(1'b0, 1'b0, 1'b1, 1'b0);
      check_all("draw.clear");

      do_reset();
      for (int i = 0; i < 300; i++) begin
         int pick = int'($urandom_range(0, 9));
         bit nz = 1'($urandom_range(0, 1));
         case (pick)
            0, 1, 2: act(1'b0, 1'b1, 1'b0, nz);
            3, 4:    act(1'b1, 1'b0, 1'b0, nz);
            5:       act(1'b1, 1'b1, 1'b0, nz);
            6, 7:    act(1'b0, 1'b0, 1'b1, nz);
            8:       act(1'b1, 1'b0, 1'b1, nz);
            default: act(1'b0, 1'b1, 1'b1, nz);
         endcase
         check_all("rand");
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
